reduction_arbiter: RTL

- Shares one projective-to-affine `Reduction` unit between two requesters, e.g. two scalar-multiplier cores.
- Arbitrates round-robin and captures the winner's (X,Y,Z) operands.
- Pulses the unit's start, waits for its finish, and returns (x,y) tagged with the requester id over a valid/ready response port.
- Contains a watchdog that aborts a hung reduction.

---
 rtl/reduction_arbiter_if.sv | 66 ++++++
 rtl/reduction_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/reduction_arbiter_if.sv
// Bundle of every handshake and data signal around the reduction arbiter:
// two requester ports, the response port and the link to the shared
// projective-to-affine Reduction unit.
//
// Handshake rule for every valid/ready pair in this bundle:
//   The producer raises valid with stable data and holds both until it
//   samples ready high on a rising edge. The transfer happens on that edge.
//   Ready may depend combinationally on valid. Valid never waits for ready.
interface reduction_arbiter_if #(
  parameter int W = 255
);
  logic         i_req0_valid;
  logic         o_req0_ready;
  logic [W-1:0] i_req0_x;
  logic [W-1:0] i_req0_y;
  logic [W-1:0] i_req0_z;

  logic         i_req1_valid;
  logic         o_req1_ready;
  logic [W-1:0] i_req1_x;
  logic [W-1:0] i_req1_y;
  logic [W-1:0] i_req1_z;

  logic         o_rsp_valid;
  logic         i_rsp_ready;
  logic         o_rsp_id;
  logic [W-1:0] o_rsp_x;
  logic [W-1:0] o_rsp_y;
  logic         o_rsp_err;

  logic         o_red_start;
  logic [W-1:0] o_red_x;
  logic [W-1:0] o_red_y;
  logic [W-1:0] o_red_z;
  logic [W-1:0] i_red_x;
  logic [W-1:0] i_red_y;
  logic         i_red_finished;

  logic         o_busy;

  // Arbiter side.
  modport slave (
    input  i_req0_valid, i_req0_x, i_req0_y, i_req0_z,
    output o_req0_ready,
    input  i_req1_valid, i_req1_x, i_req1_y, i_req1_z,
    output o_req1_ready,
    output o_rsp_valid, o_rsp_id, o_rsp_x, o_rsp_y, o_rsp_err,
    input  i_rsp_ready,
    output o_red_start, o_red_x, o_red_y, o_red_z,
    input  i_red_x, i_red_y, i_red_finished,
    output o_busy
  );

  // Environment side: requesters, response consumer and Reduction unit.
  modport master (
    output i_req0_valid, i_req0_x, i_req0_y, i_req0_z,
    input  o_req0_ready,
    output i_req1_valid, i_req1_x, i_req1_y, i_req1_z,
    input  o_req1_ready,
    input  o_rsp_valid, o_rsp_id, o_rsp_x, o_rsp_y, o_rsp_err,
    output i_rsp_ready,
    input  o_red_start, o_red_x, o_red_y, o_red_z,
    output i_red_x, i_red_y, i_red_finished,
    input  o_busy
  );
endinterface

// File: rtl/reduction_arbiter.sv
// Shares one Reduction unit between two requesters. A round-robin grant
// picks a requester in IDLE, its (X,Y,Z) is captured, the unit is started
// with a one-cycle pulse, and the affine (x,y) comes back tagged with the
// requester id. A watchdog turns a hung reduction into an error response.
// CNT_W must be wide enough that 2^CNT_W > TIMEOUT_CYC.
module reduction_arbiter #(
  parameter int W           = 255,
  parameter int TIMEOUT_CYC = 1048575,
  parameter int CNT_W       = 20
) (
  input  logic                i_clk,
  input  logic                i_rst,
  reduction_arbiter_if.slave  bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic             rr_ptr;   // requester preferred on a tie
  logic             job_id;   // owner of the job in flight
  logic [CNT_W-1:0] wd_cnt;

  logic             gnt_valid;
  logic             gnt_id;
  logic [W-1:0]     gnt_x;
  logic [W-1:0]     gnt_y;
  logic [W-1:0]     gnt_z;

  // Round-robin grant, only offered while IDLE; selects the winner's operands.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state == IDLE) begin
      if (bus.i_req0_valid && bus.i_req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = rr_ptr;
      end else if (bus.i_req0_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (bus.i_req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
    gnt_x = gnt_id ? bus.i_req1_x : bus.i_req0_x;
    gnt_y = gnt_id ? bus.i_req1_y : bus.i_req0_y;
    gnt_z = gnt_id ? bus.i_req1_z : bus.i_req0_z;
  end

  // A grant is only given to a requester that is valid, so ready doubles
  // as the accept strobe.
  assign bus.o_req0_ready = gnt_valid && !gnt_id;
  assign bus.o_req1_ready = gnt_valid &&  gnt_id;
  assign bus.o_busy       = (state != IDLE);
  assign o_dbg_state      = state;

  // Job sequencer: accept, start pulse, wait for finish or timeout, respond.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state           <= IDLE;
      rr_ptr          <= 1'b0;
      job_id          <= 1'b0;
      wd_cnt          <= '0;
      bus.o_red_start <= 1'b0;
      bus.o_red_x     <= '0;
      bus.o_red_y     <= '0;
      bus.o_red_z     <= '0;
      bus.o_rsp_valid <= 1'b0;
      bus.o_rsp_id    <= 1'b0;
      bus.o_rsp_x     <= '0;
      bus.o_rsp_y     <= '0;
      bus.o_rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // i_red_finished is deliberately ignored here.
          if (gnt_valid) begin
            bus.o_red_x     <= gnt_x;
            bus.o_red_y     <= gnt_y;
            bus.o_red_z     <= gnt_z;
            job_id          <= gnt_id;
            rr_ptr          <= ~gnt_id;
            bus.o_red_start <= 1'b1;
            state           <= START;
          end
        end
        START: begin
          bus.o_red_start <= 1'b0;
          wd_cnt          <= '0;
          state           <= BUSY;
        end
        BUSY: begin
          // A finish on the timeout cycle still returns the real result.
          if (bus.i_red_finished) begin
            bus.o_rsp_x     <= bus.i_red_x;
            bus.o_rsp_y     <= bus.i_red_y;
            bus.o_rsp_err   <= 1'b0;
            bus.o_rsp_id    <= job_id;
            bus.o_rsp_valid <= 1'b1;
            state           <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            bus.o_rsp_x     <= '0;
            bus.o_rsp_y     <= '0;
            bus.o_rsp_err   <= 1'b1;
            bus.o_rsp_id    <= job_id;
            bus.o_rsp_valid <= 1'b1;
            state           <= RESP;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.i_rsp_ready) begin
            bus.o_rsp_valid <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
